// File: rtl/sign_zero_extend_pkg.sv
// -----------------------------------------------------------------------------
// sign_zero_extend_pkg
//   Shared widths and extension-mode encodings for the immediate extender.
//   IMM_W_DEF : default raw immediate width
//   OUT_W_DEF : default extended output width
//   ext_sel_e : ExtSel encodings (EXT_ZERO / EXT_SIGN)
// -----------------------------------------------------------------------------
package sign_zero_extend_pkg;

  localparam int IMM_W_DEF = 16;
  localparam int OUT_W_DEF = 32;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_sel_e;

endpackage

// File: rtl/sign_zero_extend_ext_core.sv
// -----------------------------------------------------------------------------
// ext_core
//   Purely combinational zero/sign extender.
//   Immediate [IMM_W-1:0] : raw immediate
//   ExtSel                : EXT_ZERO or EXT_SIGN
//   OutComb   [OUT_W-1:0] : extended value, zero latency
// -----------------------------------------------------------------------------
module ext_core
  import sign_zero_extend_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] Immediate,
  input  logic             ExtSel,
  output logic [OUT_W-1:0] OutComb
);

  // Fill bit for the upper field: the immediate's MSB only in sign mode, so a
  // positive immediate sign-extends to the same value as zero extension.
  logic w_fill;

  assign w_fill  = (ExtSel == EXT_SIGN) & Immediate[IMM_W-1];
  assign OutComb = {{(OUT_W-IMM_W){w_fill}}, Immediate};

endmodule

// File: rtl/sign_zero_extend.sv
// -----------------------------------------------------------------------------
// sign_zero_extend
//   Immediate extender with a combinational tap and a one-cycle registered
//   output stage. One result per cycle, no backpressure.
//   CLK       : rising-edge clock
//   Reset     : asynchronous active-high reset (clears Out/OutValid)
//   Immediate : raw immediate field [IMM_W-1:0]
//   ExtSel    : 0 = zero-extend, 1 = sign-extend
//   InValid   : qualifies Immediate/ExtSel for capture
//   Out       : registered extended value [OUT_W-1:0]
//   OutValid  : high the cycle after a capture
//   OutComb   : combinational extended value of the current inputs
// -----------------------------------------------------------------------------
module sign_zero_extend
  import sign_zero_extend_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IMM_W-1:0] Immediate,
  input  logic             ExtSel,
  input  logic             InValid,
  output logic [OUT_W-1:0] Out,
  output logic             OutValid,
  output logic [OUT_W-1:0] OutComb
);

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out;
  logic             r_vld;

  ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .Immediate (Immediate),
    .ExtSel    (ExtSel),
    .OutComb   (w_ext)
  );

  // Data only loads on a valid beat, so Out holds across idle cycles while
  // the valid flop drops; reset wipes both, discarding any in-flight beat.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= InValid;
      if (InValid) r_out <= w_ext;
    end
  end

  assign OutComb  = w_ext;
  assign Out      = r_out;
  assign OutValid = r_vld;

endmodule

// File: tb/tb_sign_zero_extend.sv
module tb_sign_zero_extend;

  localparam int IMM_W = 16;
  localparam int OUT_W = 32;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic [IMM_W-1:0] Immediate = '0;
  logic             ExtSel = 1'b0;
  logic             InValid = 1'b0;
  logic [OUT_W-1:0] Out;
  logic             OutValid;
  logic [OUT_W-1:0] OutComb;

  int               n_assert = 0;
  int               n_fail = 0;
  logic [OUT_W-1:0] sb[$];
  logic [OUT_W-1:0] last_out = '0;

  sign_zero_extend #(.IMM_W(IMM_W), .OUT_W(OUT_W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Immediate (Immediate),
    .ExtSel    (ExtSel),
    .InValid   (InValid),
    .Out       (Out),
    .OutValid  (OutValid),
    .OutComb   (OutComb)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OUT_W-1:0] model(input logic [IMM_W-1:0] imm, input logic sel);
    logic [OUT_W-1:0] r;
    r = {{(OUT_W-IMM_W){1'b0}}, imm};
    if (sel && imm[IMM_W-1]) r[OUT_W-1:IMM_W] = '1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check comb tap, push on valid, check the
  // registered side just after the next rising edge.
  task automatic step(input string tag, input logic [IMM_W-1:0] imm, input logic sel,
                      input logic vld, input logic [OUT_W-1:0] exp);
    logic [OUT_W-1:0] e;
    Immediate = imm; ExtSel = sel; InValid = vld;
    #1;
    chk({tag, "_comb"}, OutComb, exp);
    if (vld) sb.push_back(exp);
    @(posedge CLK); #2;
    if (vld) begin
      chk({tag, "_ovld"}, {31'b0, OutValid}, 32'd1);
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_out"}, Out, e);
        last_out = e;
      end
    end else begin
      chk({tag, "_ovld"}, {31'b0, OutValid}, 32'd0);
      chk({tag, "_hold"}, Out, last_out);
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [IMM_W-1:0] ri;
    logic             rs;
    #1 Reset = 1'b1;
    #2;
    chk("rst_out", Out, 32'h0);
    chk("rst_ovld", {31'b0, OutValid}, 32'd0);
    // InValid ignored while in reset
    Immediate = 16'h8007; ExtSel = 1'b1; InValid = 1'b1;
    @(posedge CLK); #2;
    chk("rst_ign_out", Out, 32'h0);
    chk("rst_ign_ovld", {31'b0, OutValid}, 32'd0);
    chk("rst_comb", OutComb, 32'hFFFF8007);
    @(negedge CLK);
    Reset = 1'b0; InValid = 1'b0;
    last_out = '0;

    // Directed vectors, back-to-back
    step("zx7",    16'h0007, 1'b0, 1'b1, 32'h00000007);
    step("sxA",    16'h000A, 1'b1, 1'b1, 32'h0000000A);
    step("sx8007", 16'h8007, 1'b1, 1'b1, 32'hFFFF8007);
    step("zx8007", 16'h8007, 1'b0, 1'b1, 32'h00008007);
    step("sxFFFF", 16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
    step("zxFFFF", 16'hFFFF, 1'b0, 1'b1, 32'h0000FFFF);
    step("sx7FFF", 16'h7FFF, 1'b1, 1'b1, 32'h00007FFF);
    step("zx7FFF", 16'h7FFF, 1'b0, 1'b1, 32'h00007FFF);
    step("sx0",    16'h0000, 1'b1, 1'b1, 32'h00000000);
    step("sx8000", 16'h8000, 1'b1, 1'b1, 32'hFFFF8000);

    // Hold for 3 idle cycles with changing inputs
    step("hold1", 16'h1234, 1'b1, 1'b0, 32'h00001234);
    step("hold2", 16'hF00D, 1'b1, 1'b0, 32'hFFFFF00D);
    step("hold3", 16'hF00D, 1'b0, 1'b0, 32'h0000F00D);

    // Capture, then reset between edges with a beat pending
    step("pre_rst", 16'hC0DE, 1'b1, 1'b1, 32'hFFFFC0DE);
    Immediate = 16'h1234; ExtSel = 1'b0; InValid = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_out", Out, 32'h0);
    chk("mid_rst_ovld", {31'b0, OutValid}, 32'd0);
    chk("mid_rst_comb", OutComb, 32'h00001234);
    @(posedge CLK); #2;
    chk("mid_rst_edge_out", Out, 32'h0);
    @(negedge CLK);
    Reset = 1'b0; InValid = 1'b0;
    last_out = '0;
    @(posedge CLK); #2;
    chk("post_rst_ovld", {31'b0, OutValid}, 32'd0);
    chk("post_rst_out", Out, 32'h0);
    @(negedge CLK);
    step("post_rst_cap", 16'hBEEF, 1'b1, 1'b1, 32'hFFFFBEEF);

    // Random mix of valid/idle beats
    for (int i = 0; i < 40; i++) begin
      ri = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      step("rnd", ri, rs, 1'($urandom_range(0, 3) != 0), model(ri, rs));
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
